// File: rtl/rotation_sequencer.sv
// Multi-pass rotation controller: splits an N-bit rotate request into passes of
// at most 2^STEP_W-1 through an external single-pass rotator, feeding results back.
module rotation_sequencer #(
  parameter int N       = 16,
  parameter int AMT_W   = 4,
  parameter int STEP_W  = 3,
  parameter int OPT_DIR = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [N-1:0]      i_value,
  input  logic [AMT_W-1:0]  i_amount,
  input  logic              i_dir,
  output logic [N-1:0]      o_sh_value,
  output logic [STEP_W-1:0] o_sh_rot,
  output logic              o_sh_dir,
  input  logic [N-1:0]      i_sh_result,
  output logic              o_busy,
  output logic              o_done,
  output logic [N-1:0]      o_result,
  output logic [AMT_W-1:0]  o_passes
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AMT_W-1:0] HALF_C     = AMT_W'(N / 2);
  localparam logic [AMT_W-1:0] STEP_MAX_C = AMT_W'((1 << STEP_W) - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       work_q, work_d;
  logic [AMT_W-1:0]   rem_q, rem_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [N-1:0]       result_q, result_d;
  logic [AMT_W-1:0]   passes_q, passes_d;
  logic [AMT_W-1:0]   step_s;

  // Per-pass amount: remaining amount clamped to the datapath maximum
  always_comb begin
    step_s = rem_q;
    if (rem_q > STEP_MAX_C) begin
      step_s = STEP_MAX_C;
    end else begin
      step_s = rem_q;
    end
  end

  // Next-state and datapath bookkeeping
  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    result_d = result_q;
    passes_d = passes_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          work_d = i_value;
          cnt_d  = {AMT_W{1'b0}};
          // N - amount is the modular negation in AMT_W bits
          if ((OPT_DIR != 0) && (i_amount > HALF_C)) begin
            rem_d = {AMT_W{1'b0}} - i_amount;
            dir_d = ~i_dir;
          end else begin
            rem_d = i_amount;
            dir_d = i_dir;
          end
          if (rem_d == {AMT_W{1'b0}}) begin
            state_d  = S_DONE;
            result_d = i_value;
            passes_d = {AMT_W{1'b0}};
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        work_d = i_sh_result;
        rem_d  = rem_q - step_s;
        cnt_d  = cnt_q + {{(AMT_W-1){1'b0}}, 1'b1};
        if (rem_d == {AMT_W{1'b0}}) begin
          state_d  = S_DONE;
          result_d = i_sh_result;
          passes_d = cnt_d;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      work_q   <= {N{1'b0}};
      rem_q    <= {AMT_W{1'b0}};
      cnt_q    <= {AMT_W{1'b0}};
      dir_q    <= 1'b0;
      result_q <= {N{1'b0}};
      passes_q <= {AMT_W{1'b0}};
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      result_q <= result_d;
      passes_q <= passes_d;
    end
  end

  // Outputs decoded from state and registers only
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_DONE);
    o_result   = result_q;
    o_passes   = passes_q;
    o_sh_value = {N{1'b0}};
    o_sh_rot   = {STEP_W{1'b0}};
    o_sh_dir   = 1'b0;
    if (state_q == S_RUN) begin
      o_sh_value = work_q;
      o_sh_rot   = step_s[STEP_W-1:0];
      o_sh_dir   = dir_q;
    end else begin
      o_sh_value = {N{1'b0}};
      o_sh_rot   = {STEP_W{1'b0}};
      o_sh_dir   = 1'b0;
    end
  end

endmodule

// File: tb/tb_rotation_sequencer.sv
// Directed bench for rotation_sequencer: one instance per OPT_DIR setting, each
// closed around a behavioural single-pass rotator.
module tb_rotation_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [15:0] value = 16'h0;
  logic [3:0]  amount = 4'h0;
  logic        dir = 1'b0;
  bit          sel = 1'b0;

  logic [15:0] shv0, shv1, res0, res1, out0, out1;
  logic [2:0]  rot0, rot1;
  logic        shd0, shd1, busy0, busy1, done0, done1;
  logic [3:0]  pas0, pas1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rot_model(input logic [15:0] v, input logic [2:0] a, input logic left);
    logic [31:0] t;
    if (left) begin
      t = {v, v} << a;
      return t[31:16];
    end else begin
      t = {v, v} >> a;
      return t[15:0];
    end
  endfunction

  assign res0 = rot_model(shv0, rot0, shd0);
  assign res1 = rot_model(shv1, rot1, shd1);

  rotation_sequencer #(.N(16), .AMT_W(4), .STEP_W(3), .OPT_DIR(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start0), .i_value(value),
    .i_amount(amount), .i_dir(dir), .o_sh_value(shv0), .o_sh_rot(rot0),
    .o_sh_dir(shd0), .i_sh_result(res0), .o_busy(busy0), .o_done(done0),
    .o_result(out0), .o_passes(pas0));

  rotation_sequencer #(.N(16), .AMT_W(4), .STEP_W(3), .OPT_DIR(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_value(value),
    .i_amount(amount), .i_dir(dir), .o_sh_value(shv1), .o_sh_rot(rot1),
    .o_sh_dir(shd1), .i_sh_result(res1), .o_busy(busy1), .o_done(done1),
    .o_result(out1), .o_passes(pas1));

  wire        m_busy   = sel ? busy1 : busy0;
  wire        m_done   = sel ? done1 : done0;
  wire [15:0] m_result = sel ? out1 : out0;
  wire [3:0]  m_passes = sel ? pas1 : pas0;
  wire [2:0]  m_rot    = sel ? rot1 : rot0;
  wire        m_dir    = sel ? shd1 : shd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          opt;
    logic [15:0] value;
    logic [3:0]  amount;
    logic        dir;
    logic [15:0] exp_result;
    logic [3:0]  exp_passes;
    logic [2:0]  exp_rot0;
    logic        exp_dir0;
  } vec_t;

  vec_t vecs[10];

  // Issue one request and follow it to o_done; returns observations
  task automatic run_req(input bit opt, input logic [15:0] v, input logic [3:0] a, input logic d,
                         output logic [15:0] res, output logic [3:0] pas, output int lat,
                         output int busy_n, output logic [2:0] r0, output logic d0);
    sel = opt;
    @(negedge clk);
    value = v; amount = a; dir = d;
    if (opt) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    value = 16'hFFFF; amount = 4'd3; dir = ~d;
    r0 = m_rot; d0 = m_dir;
    lat = 0; busy_n = 0;
    while (!m_done && lat < 20) begin
      busy_n += int'(m_busy);
      @(negedge clk);
      lat++;
    end
    busy_n += int'(m_busy);
    if (!m_done) begin
      errors++;
      $display("FAIL timeout: o_done not seen within %0d cycles", lat);
    end
    res = m_result; pas = m_passes;
  endtask

  initial begin
    logic [15:0] res;
    logic [3:0]  pas;
    logic [2:0]  r0;
    logic        d0;
    int          lat, busy_n, dones;

    vecs[0] = '{1'b0, 16'h0006, 4'd1,  1'b0, 16'h0003, 4'd1, 3'd1, 1'b0};
    vecs[1] = '{1'b0, 16'h0001, 4'd10, 1'b1, 16'h0400, 4'd2, 3'd7, 1'b1};
    vecs[2] = '{1'b1, 16'h0001, 4'd10, 1'b1, 16'h0400, 4'd1, 3'd6, 1'b0};
    vecs[3] = '{1'b0, 16'hBEEF, 4'd0,  1'b0, 16'hBEEF, 4'd0, 3'd0, 1'b0};
    vecs[4] = '{1'b0, 16'h8001, 4'd15, 1'b0, 16'h0003, 4'd3, 3'd7, 1'b0};
    vecs[5] = '{1'b1, 16'h1234, 4'd8,  1'b1, 16'h3412, 4'd2, 3'd7, 1'b1};
    vecs[6] = '{1'b0, 16'hA5C3, 4'd4,  1'b0, 16'h3A5C, 4'd1, 3'd4, 1'b0};
    vecs[7] = '{1'b1, 16'h0001, 4'd15, 1'b0, 16'h0002, 4'd1, 3'd1, 1'b1};
    vecs[8] = '{1'b0, 16'h00FF, 4'd7,  1'b1, 16'h7F80, 4'd1, 3'd7, 1'b1};
    vecs[9] = '{1'b0, 16'h0001, 4'd14, 1'b1, 16'h4000, 4'd2, 3'd7, 1'b1};

    repeat (2) @(negedge clk);
    check("reset_busy",   {31'd0, busy0}, 32'd0);
    check("reset_done",   {31'd0, done0}, 32'd0);
    check("reset_result", {16'd0, out0},  32'd0);
    check("reset_shval",  {16'd0, shv0},  32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_req(vecs[i].opt, vecs[i].value, vecs[i].amount, vecs[i].dir, res, pas, lat, busy_n, r0, d0);
      check($sformatf("v%0d_result", i), {16'd0, res}, {16'd0, vecs[i].exp_result});
      check($sformatf("v%0d_passes", i), {28'd0, pas}, {28'd0, vecs[i].exp_passes});
      check($sformatf("v%0d_latency", i), lat, {28'd0, vecs[i].exp_passes});
      check($sformatf("v%0d_busy_cycles", i), busy_n, {28'd0, vecs[i].exp_passes} + 32'd1);
      check($sformatf("v%0d_rot0", i), {29'd0, r0}, {29'd0, vecs[i].exp_rot0});
      check($sformatf("v%0d_dir0", i), {31'd0, d0}, {31'd0, vecs[i].exp_dir0});
      @(negedge clk);
      check($sformatf("v%0d_done_width", i), {31'd0, m_done}, 32'd0);
      check($sformatf("v%0d_idle_after", i), {31'd0, m_busy}, 32'd0);
    end

    // Second start during RUN must be dropped
    sel = 1'b0;
    @(negedge clk);
    value = 16'h8001; amount = 4'd15; dir = 1'b0; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    value = 16'h1234; amount = 4'd3; dir = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    dones = 0; res = 16'h0; pas = 4'h0;
    for (int c = 0; c < 10; c++) begin
      if (done0) begin
        dones++; res = out0; pas = pas0;
      end
      @(negedge clk);
    end
    check("ign_done_count", dones, 32'd1);
    check("ign_result", {16'd0, res}, 32'h0003);
    check("ign_passes", {28'd0, pas}, 32'd3);
    check("ign_idle", {31'd0, busy0}, 32'd0);

    // Asynchronous reset in the middle of a multi-pass request
    @(negedge clk);
    value = 16'h0001; amount = 4'd14; dir = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    check("rst_pre_busy", {31'd0, busy0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy0}, 32'd0);
    check("rst_result", {16'd0, out0},  32'd0);
    check("rst_passes", {28'd0, pas0},  32'd0);
    check("rst_shrot",  {29'd0, rot0},  32'd0);
    dones = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      dones += int'(done0);
    end
    check("rst_no_done", dones, 32'd0);
    rst_n = 1'b1;
    run_req(1'b0, 16'h0006, 4'd1, 1'b0, res, pas, lat, busy_n, r0, d0);
    check("post_rst_result", {16'd0, res}, 32'h0003);
    check("post_rst_passes", {28'd0, pas}, 32'd1);
    check("post_rst_latency", lat, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
